// File: rtl/wshb_mire_pkg.sv
// Shared video constants and the grid test-pattern function
// used by the frame-buffer pattern generator.
package wshb_mire_pkg;

  localparam int HDISP_DEF = 800;
  localparam int VDISP_DEF = 480;

  typedef logic [31:0] pixel_t;

  localparam int     GRID_BITS = 4;
  localparam pixel_t WHITE     = 32'h00FFFFFF;
  localparam pixel_t BLACK     = 32'h00000000;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  // White line on every 16th column and row, black elsewhere
  function automatic pixel_t mire_pixel(
    input logic [31:0] x,
    input logic [31:0] y
  );
    if (x[GRID_BITS-1:0] == '0 ||
        y[GRID_BITS-1:0] == '0)
      return WHITE;
    return BLACK;
  endfunction

endpackage

// File: rtl/wshb_mire_if.sv
// Wishbone classic-cycle bus bundle between one master
// and one slave.
interface wshb_if #(
  parameter int DATA_BYTES = 4
);

  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [31:0]             adr;
  logic [8*DATA_BYTES-1:0] dat_ms;
  logic [DATA_BYTES-1:0]   sel;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport master (
    output cyc, stb, we, adr, dat_ms,
    output sel, cti, bte,
    input  ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms,
    input  sel, cti, bte,
    output ack, err, rty
  );

endinterface

// File: rtl/wshb_mire.sv
// Grid test-pattern writer: walks the frame buffer as a
// Wishbone master, releasing the bus every BURST beats.
module wshb_mire
  import wshb_mire_pkg::*;
#(
  parameter int HDISP = HDISP_DEF,
  parameter int VDISP = VDISP_DEF,
  parameter int BURST = 64
) (
  input  logic   sys_clk,
  input  logic   sys_rst,
  input  logic   enable,
  output logic   frame_done,
  wshb_if.master wshb_ifm
);

  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam int BW = $clog2(BURST + 1);

  logic [1:0]    state;
  logic          run;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [BW-1:0] bcnt;

  logic          term;
  logic          rty_only;
  logic          acc;
  logic          eol;
  logic          last;
  logic          bend;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;

  // A bare rty terminates the beat but is not an acceptance
  assign term = wshb_ifm.ack | wshb_ifm.err | wshb_ifm.rty;
  assign rty_only = wshb_ifm.rty &
                    ~(wshb_ifm.ack | wshb_ifm.err);
  assign acc = (state == S_WRITE) & term & ~rty_only;

  assign eol  = (x == XW'(HDISP - 1));
  assign last = eol && (y == YW'(VDISP - 1));
  assign bend = (bcnt == BW'(BURST - 1));

  assign nx = eol ? '0 : x + 1'b1;
  assign ny = !eol ? y :
              (y == YW'(VDISP - 1)) ? '0 : y + 1'b1;

  assign wshb_ifm.cyc = run;
  assign wshb_ifm.stb = run;
  assign wshb_ifm.we  = 1'b1;
  assign wshb_ifm.sel = '1;
  assign wshb_ifm.cti = 3'b000;
  assign wshb_ifm.bte = 2'b00;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state           <= S_IDLE;
      run             <= 1'b0;
      x               <= '0;
      y               <= '0;
      bcnt            <= '0;
      frame_done      <= 1'b0;
      wshb_ifm.adr    <= '0;
      wshb_ifm.dat_ms <= WHITE;
    end else begin
      frame_done <= acc && last;
      unique case (state)
        S_IDLE: begin
          if (enable) begin
            state <= S_WRITE;
            run   <= 1'b1;
          end
        end
        S_WRITE: begin
          if (acc) begin
            x <= nx;
            y <= ny;
            // Raster order makes the byte address a running +4
            wshb_ifm.adr <= last ? '0 : wshb_ifm.adr + 32'd4;
            wshb_ifm.dat_ms <= mire_pixel(32'(nx), 32'(ny));
            if (last || bend) begin
              bcnt  <= '0;
              state <= S_PAUSE;
              run   <= 1'b0;
            end else begin
              bcnt <= bcnt + 1'b1;
              if (!enable) begin
                state <= S_IDLE;
                run   <= 1'b0;
              end
            end
          end
        end
        S_PAUSE: begin
          if (enable) begin
            state <= S_WRITE;
            run   <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          run   <= 1'b0;
        end
      endcase
    end
  end

endmodule
